// File: rtl/nexys_starship_spawn_scheduler_if.sv
// Bus between the game/room logic and the spawn scheduler.
// The master drives the game inputs; the slave reports spawns and status.
interface nexys_starship_spawn_scheduler_if;
  logic       play_flag;
  logic       game_over;
  logic       tick;
  logic [3:0] room_busy;
  logic [3:0] spawn;
  logic [7:0] spawn_count;
  logic [3:0] interval;
  logic [1:0] sched_state;

  modport master (
    output play_flag, game_over, tick, room_busy,
    input  spawn, spawn_count, interval, sched_state
  );

  modport slave (
    input  play_flag, game_over, tick, room_busy,
    output spawn, spawn_count, interval, sched_state
  );
endinterface

// File: rtl/nexys_starship_spawn_scheduler.sv
// Monster spawn scheduler: tick countdown, LFSR-seeded free-room scan and an
// occupancy cap, with an interval that shortens every RAMP_SPAWNS spawns.
//
// state | meaning
// IDLE  | not playing (reset or paused); spawn held 0
// WAIT  | counting ticks down to the next spawn
// PICK  | choosing a free room; stays here while the occupancy cap is reached
// HALT  | game over; spawn held 0 until play_flag and game_over both drop
module nexys_starship_spawn_scheduler #(
  parameter int unsigned INIT_INTERVAL = 8,
  parameter int unsigned MIN_INTERVAL  = 2,
  parameter int unsigned RAMP_SPAWNS   = 4,
  parameter int unsigned MAX_ACTIVE    = 3,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input logic Clk,
  input logic Reset,
  nexys_starship_spawn_scheduler_if.slave sched
);

  localparam int unsigned RW      = (RAMP_SPAWNS > 1) ? $clog2(RAMP_SPAWNS) : 1;
  localparam logic [3:0]  INIT_IV = 4'(INIT_INTERVAL);
  localparam logic [3:0]  MIN_IV  = 4'(MIN_INTERVAL);
  localparam logic [2:0]  MAX_A   = 3'(MAX_ACTIVE);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_SPAWNS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PICK = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t          state_q;
  logic [3:0]      spawn_q;
  logic [7:0]      count_q;
  logic [3:0]      interval_q;
  logic [3:0]      cd_q;
  logic [RW-1:0]   ramp_q;
  logic [7:0]      lfsr_q;

  logic [2:0]      active;
  logic [1:0]      idx;
  logic [3:0]      pick_oh;
  logic            found;
  logic            can_pick;
  logic            ramp_hit;
  logic [3:0]      next_iv;

  // Rotating scan from the LFSR-chosen start to the first free room.
  always_comb begin
    active  = 3'd0;
    for (int i = 0; i < 4; i++) active = active + {2'b00, sched.room_busy[i]};
    pick_oh = 4'b0000;
    found   = 1'b0;
    idx     = lfsr_q[1:0];
    for (int k = 0; k < 4; k++) begin
      idx = lfsr_q[1:0] + 2'(k);
      if (!found && !sched.room_busy[idx]) begin
        pick_oh = 4'b0001 << idx;
        found   = 1'b1;
      end
    end
    can_pick = found && (active < MAX_A);
    ramp_hit = (ramp_q == RAMP_LAST);
    next_iv  = (ramp_hit && interval_q > MIN_IV) ? interval_q - 4'd1 : interval_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      spawn_q    <= 4'b0000;
      count_q    <= 8'd0;
      interval_q <= INIT_IV;
      cd_q       <= 4'd0;
      ramp_q     <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      spawn_q <= 4'b0000;
      if (sched.game_over) begin
        state_q <= HALT;
      end else begin
        case (state_q)
          IDLE: begin
            if (sched.play_flag) begin
              state_q <= WAIT;
              cd_q    <= interval_q;
            end
          end
          WAIT: begin
            if (!sched.play_flag) begin
              state_q <= IDLE;
            end else if (sched.tick) begin
              cd_q <= cd_q - 4'd1;
              if (cd_q == 4'd1) state_q <= PICK;
            end
          end
          PICK: begin
            if (!sched.play_flag) begin
              state_q <= IDLE;
            end else if (can_pick) begin
              spawn_q    <= pick_oh;
              lfsr_q     <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
              count_q    <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
              ramp_q     <= ramp_hit ? '0 : ramp_q + RW'(1);
              interval_q <= next_iv;
              cd_q       <= next_iv;
              state_q    <= WAIT;
            end
          end
          HALT: begin
            // lfsr is kept so the next game takes a different room sequence
            if (!sched.play_flag) begin
              state_q    <= IDLE;
              interval_q <= INIT_IV;
              count_q    <= 8'd0;
              ramp_q     <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sched.spawn       = spawn_q;
  assign sched.spawn_count = count_q;
  assign sched.interval    = interval_q;
  assign sched.sched_state = state_q;

endmodule

// File: tb/tb_nexys_starship_spawn_scheduler.sv
// Scoreboard bench for the spawn scheduler: a game-rule model predicts each
// spawn, a negedge monitor pops and compares whatever the DUT presents.
module tb_nexys_starship_spawn_scheduler;

  localparam int INIT = 8;
  localparam int MINI = 2;
  localparam int RAMP = 4;
  localparam int MAXA = 3;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  nexys_starship_spawn_scheduler_if sif();

  nexys_starship_spawn_scheduler dut (
    .Clk   (Clk),
    .Reset (Reset),
    .sched (sif)
  );

  typedef struct {
    logic [3:0] spawn;
    int         count;
    int         iv;
    int         due;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // game-rule model
  int         m_phase;  // 0 idle, 1 waiting, 2 picking, 3 halted
  int         m_seen;
  int         m_iv;
  int         m_cnt;
  int         m_ramp;
  logic [7:0] m_lfsr;

  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        chk("spawn", int'(sif.spawn), int'(e.spawn));
        chk("spawn_count_at_spawn", int'(sif.spawn_count), e.count);
        chk("interval_at_spawn", int'(sif.interval), e.iv);
      end else if (sif.spawn != 4'b0000) begin
        chk("unexpected_spawn", int'(sif.spawn), 0);
      end
    end
  end

  task automatic model_reset();
    m_phase = 0; m_seen = 0; m_iv = INIT; m_cnt = 0; m_ramp = 0; m_lfsr = 8'hA5;
  endtask

  task automatic model_step(input logic p, input logic g, input logic t, input logic [3:0] b);
    int   start;
    int   room;
    exp_t e;
    if (g) begin
      m_phase = 3;
    end else if (m_phase == 0) begin
      if (p) begin m_phase = 1; m_seen = 0; end
    end else if (m_phase == 1) begin
      if (!p) m_phase = 0;
      else if (t) begin
        m_seen++;
        if (m_seen == m_iv) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (!p) m_phase = 0;
      else if ($countones(b) < MAXA && b != 4'hF) begin
        start = int'(m_lfsr[1:0]);
        room  = -1;
        for (int k = 0; k < 4; k++)
          if (room < 0 && !b[(start + k) % 4]) room = (start + k) % 4;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (m_cnt < 255) m_cnt++;
        m_ramp++;
        if (m_ramp == RAMP) begin
          m_ramp = 0;
          if (m_iv > MINI) m_iv--;
        end
        e.spawn = 4'(1 << room);
        e.count = m_cnt;
        e.iv    = m_iv;
        e.due   = cyc + 1;
        sbq.push_back(e);
        m_phase = 1;
        m_seen  = 0;
      end
    end else begin
      if (!p) begin m_phase = 0; m_iv = INIT; m_cnt = 0; m_ramp = 0; end
    end
  endtask

  task automatic step(input logic p, input logic g, input logic t, input logic [3:0] b);
    @(posedge Clk); #1;
    chk("sched_state", int'(sif.sched_state), m_phase);
    chk("interval", int'(sif.interval), m_iv);
    chk("spawn_count", int'(sif.spawn_count), m_cnt);
    sif.play_flag = p; sif.game_over = g; sif.tick = t; sif.room_busy = b;
    model_step(p, g, t, b);
  endtask

  task automatic do_reset();
    @(posedge Clk); #3;
    Reset = 1'b1;
    #1;
    chk("reset_spawn", int'(sif.spawn), 0);
    chk("reset_state", int'(sif.sched_state), 0);
    chk("reset_count", int'(sif.spawn_count), 0);
    chk("reset_interval", int'(sif.interval), INIT);
    sif.play_flag = 0; sif.game_over = 0; sif.tick = 0; sif.room_busy = 0;
    model_reset();
    sbq.delete();
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic run_until_count(input int n, input int tick_every, input logic [3:0] b);
    for (int i = 0; i < 2000 && m_cnt < n; i++) step(1, 0, (i % tick_every) == 0, b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int want;
    int prev;
    logic p, g, t;
    logic [3:0] b;
    sif.play_flag = 0; sif.game_over = 0; sif.tick = 0; sif.room_busy = 0;
    model_reset();

    // first spawn from seed A5 lands in room index 1
    do_reset();
    run_until_count(1, 4, 4'b0000);
    step(1, 0, 0, 4'b0000);
    chk("first_spawn", int'(sif.spawn), 4'b0010);
    chk("first_count", int'(sif.spawn_count), 1);

    // busy start room is skipped
    do_reset();
    run_until_count(1, 4, 4'b0010);
    step(1, 0, 0, 4'b0010);
    chk("skip_busy", int'(sif.spawn), 4'b0100);

    // interval ramp down to the floor
    do_reset();
    want = -1;
    for (int i = 0; i < 3000 && m_cnt < 28; i++) begin
      prev = m_cnt;
      step(1, 0, (i % 2) == 0, 4'b0000);
      if (want >= 0) begin chk("ramp_interval", int'(sif.interval), want); want = -1; end
      if (m_cnt != prev)
        want = (m_cnt == 4) ? 7 : (m_cnt == 8) ? 6 : (m_cnt >= 24) ? 2 : -1;
    end

    // deferral at the occupancy cap, then release
    do_reset();
    for (int i = 0; i < 200 && m_phase != 2; i++) step(1, 0, (i % 3) == 0, 4'b1110);
    for (int i = 0; i < 50; i++) step(1, 0, (i % 3) == 0, 4'b1110);
    chk("defer_state", int'(sif.sched_state), 2);
    step(1, 0, 0, 4'b0110);
    step(1, 0, 0, 4'b0110);
    chk("release_onehot", $countones(sif.spawn), 1);
    chk("release_free_room", int'(sif.spawn & 4'b0110), 0);

    // game over during WAIT, then restart
    do_reset();
    run_until_count(5, 2, 4'b0000);
    step(1, 0, 1, 4'b0000);
    for (int i = 0; i < 200; i++) step(1, 1, (i % 2) == 0, 4'b0000);
    chk("halt_state", int'(sif.sched_state), 3);
    step(0, 0, 0, 4'b0000);
    step(0, 0, 0, 4'b0000);
    chk("restart_state", int'(sif.sched_state), 0);
    chk("restart_interval", int'(sif.interval), INIT);
    chk("restart_count", int'(sif.spawn_count), 0);

    // asynchronous reset while a pick is pending
    do_reset();
    run_until_count(2, 2, 4'b0000);
    for (int i = 0; i < 200 && m_phase != 2; i++) step(1, 0, (i % 2) == 0, 4'b1110);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 4'b1110);
    do_reset();
    run_until_count(1, 4, 4'b0000);
    step(1, 0, 0, 4'b0000);
    chk("post_reset_first_spawn", int'(sif.spawn), 4'b0010);

    // randomized play with pauses, game overs and changing occupancy
    do_reset();
    p = 1; g = 0; b = 0;
    for (int i = 0; i < 5000; i++) begin
      if (p && $urandom_range(0, 99) < 2) p = 0;
      else if (!p && $urandom_range(0, 99) < 20) p = 1;
      if (!g && $urandom_range(0, 999) < 5) g = 1;
      else if (g && $urandom_range(0, 99) < 10) g = 0;
      t = ($urandom_range(0, 2) == 0);
      if ((i % 12) == 0) b = 4'($urandom_range(0, 15));
      step(p, g, t, b);
    end

    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'b0000);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
